hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage RV32 pipeline. Sits beside id_stage and drives the pipeline-register enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Sequences three events: load-use bubbles in ID, taken-branch flushes from EX, and data-memory wait states with a timeout.
- Small FSM plus counters. No datapath of its own.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: ID/EX hazard sources, memory handshake,
// and the stage enables/flushes it drives. The slave modport is the scheduler side.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ack;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       bus_error;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           branch_taken, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           bus_error
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           branch_taken, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           bus_error
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: load-use bubbles, branch flushes,
// data-memory wait states with timeout. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, ERROR} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  state_t     eff_state;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic hz;
  logic mem_stall;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, bus_error;

  assign hz = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign mem_stall = bus.mem_req && !bus.mem_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // An acked MEM_WAIT cycle behaves exactly like the state it froze, so decode that state instead.
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    eff_state   = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    bus_error   = 1'b0;

    if (state_q == MEM_WAIT) begin
      if (bus.mem_ack) begin
        eff_state  = saved_q;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end
      end
    end

    case (eff_state)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          saved_d    = RUN;
          wait_cnt_d = 8'd1;
        end else if (bus.branch_taken) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (hz) begin
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          state_d     = RUN;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          state_d   = RUN;
        end
      end

      // ID holds a wrong-path instruction here, so hz is deliberately not consulted.
      FLUSH: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          saved_d    = FLUSH;
          wait_cnt_d = 8'd1;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          if_id_flush = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            state_d = RUN;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end

      ERROR: begin
        bus_error = 1'b1;
      end

      default: begin
      end
    endcase

    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      bus_error   = 1'b0;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.bus_error   = bus_error;

`ifdef HAZARD_PERF_EN
  // Saturating event counters; pc_en is already forced low under reset, so gate on reset explicitly.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (if_id_flush && (flush_cycles != 32'hFFFF_FFFF)) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Output vector order: pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bus_error.
module tb_hazard_ctrl;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  localparam logic [6:0] O_RUN   = 7'b1111000;
  localparam logic [6:0] O_HZ    = 7'b0011010;
  localparam logic [6:0] O_BR    = 7'b1111110;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_FRZ   = 7'b0000000;
  localparam logic [6:0] O_ERR   = 7'b0000001;

  wire [6:0] outs = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
                     hif.if_id_flush, hif.id_ex_flush, hif.bus_error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    hif.id_rs1       = 5'd0;
    hif.id_rs2       = 5'd0;
    hif.id_use_rs1   = 1'b0;
    hif.id_use_rs2   = 1'b0;
    hif.ex_rd        = 5'd0;
    hif.ex_mem_read  = 1'b0;
    hif.branch_taken = 1'b0;
    hif.mem_req      = 1'b0;
    hif.mem_ack      = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    hif.branch_taken = 1'b1;
    hif.mem_req      = 1'b1;
    #1;
    tests++;
    if (outs !== O_FRZ) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", outs, O_FRZ);
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL reset_release_run: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_load_use;
    hif.ex_mem_read = 1'b1;
    hif.ex_rd       = 5'd1;
    hif.id_rs1      = 5'd1;
    hif.id_use_rs1  = 1'b1;
    #1;
    tests++;
    if (outs !== O_HZ) begin
      fails++;
      $display("[TB] FAIL load_use_rs1: got %b expected %b", outs, O_HZ);
    end
    tick();
    hif.ex_mem_read = 1'b0;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL load_use_release: got %b expected %b", outs, O_RUN);
    end
    tick();
    idle_inputs();
    hif.ex_mem_read = 1'b1;
    hif.ex_rd       = 5'd5;
    hif.id_rs1      = 5'd5;
    hif.id_rs2      = 5'd5;
    hif.id_use_rs2  = 1'b1;
    #1;
    tests++;
    if (outs !== O_HZ) begin
      fails++;
      $display("[TB] FAIL load_use_rs2: got %b expected %b", outs, O_HZ);
    end
    tick();
    hif.id_use_rs2 = 1'b0;
    hif.ex_rd      = 5'd7;
    hif.id_rs1     = 5'd7;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL match_not_used: got %b expected %b", outs, O_RUN);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_x0;
    hif.ex_mem_read = 1'b1;
    hif.ex_rd       = 5'd0;
    hif.id_rs1      = 5'd0;
    hif.id_use_rs1  = 1'b1;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL x0_no_hazard: got %b expected %b", outs, O_RUN);
    end
    tick();
    hif.ex_mem_read = 1'b0;
    hif.ex_rd       = 5'd3;
    hif.id_rs1      = 5'd3;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL non_load_no_hazard: got %b expected %b", outs, O_RUN);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch;
    hif.branch_taken = 1'b1;
    #1;
    tests++;
    if (outs !== O_BR) begin
      fails++;
      $display("[TB] FAIL branch_cycle0: got %b expected %b", outs, O_BR);
    end
    tick();
    hif.branch_taken = 1'b0;
    #1;
    tests++;
    if (outs !== O_FLUSH) begin
      fails++;
      $display("[TB] FAIL branch_cycle1: got %b expected %b", outs, O_FLUSH);
    end
    tick();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL branch_done: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_branch_over_hz;
    hif.branch_taken = 1'b1;
    hif.ex_mem_read  = 1'b1;
    hif.ex_rd        = 5'd9;
    hif.id_rs1       = 5'd9;
    hif.id_use_rs1   = 1'b1;
    #1;
    tests++;
    if (outs !== O_BR) begin
      fails++;
      $display("[TB] FAIL branch_beats_hz: got %b expected %b", outs, O_BR);
    end
    tick();
    hif.branch_taken = 1'b0;
    #1;
    tests++;
    if (outs !== O_FLUSH) begin
      fails++;
      $display("[TB] FAIL flush_ignores_hz: got %b expected %b", outs, O_FLUSH);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL branch_hz_done: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_mem_wait;
    hif.mem_req = 1'b1;
    hif.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs !== O_FRZ) begin
        fails++;
        $display("[TB] FAIL mem_wait_cycle%0d: got %b expected %b", i, outs, O_FRZ);
      end
      tick();
    end
    hif.mem_ack = 1'b1;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL mem_ack_cycle: got %b expected %b", outs, O_RUN);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL mem_after_ack: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_hz_after_mem;
    hif.mem_req     = 1'b1;
    hif.ex_mem_read = 1'b1;
    hif.ex_rd       = 5'd4;
    hif.id_rs2      = 5'd4;
    hif.id_use_rs2  = 1'b1;
    #1;
    tests++;
    if (outs !== O_FRZ) begin
      fails++;
      $display("[TB] FAIL mem_beats_hz: got %b expected %b", outs, O_FRZ);
    end
    tick();
    hif.mem_ack = 1'b1;
    #1;
    tests++;
    if (outs !== O_HZ) begin
      fails++;
      $display("[TB] FAIL hz_on_ack: got %b expected %b", outs, O_HZ);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL hz_after_mem_done: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_flush_mem;
    hif.branch_taken = 1'b1;
    tick();
    hif.branch_taken = 1'b0;
    hif.mem_req      = 1'b1;
    #1;
    tests++;
    if (outs !== O_FRZ) begin
      fails++;
      $display("[TB] FAIL flush_freeze: got %b expected %b", outs, O_FRZ);
    end
    tick();
    tick();
    hif.mem_ack = 1'b1;
    #1;
    tests++;
    if (outs !== O_FLUSH) begin
      fails++;
      $display("[TB] FAIL flush_resume_on_ack: got %b expected %b", outs, O_FLUSH);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL flush_mem_done: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_timeout;
    hif.mem_req = 1'b1;
    hif.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (outs !== O_FRZ) begin
        fails++;
        $display("[TB] FAIL timeout_wait%0d: got %b expected %b", i, outs, O_FRZ);
      end
      tick();
    end
    #1;
    tests++;
    if (outs !== O_ERR) begin
      fails++;
      $display("[TB] FAIL timeout_error: got %b expected %b", outs, O_ERR);
    end
    tick();
    hif.mem_ack = 1'b1;
    #1;
    tests++;
    if (outs !== O_ERR) begin
      fails++;
      $display("[TB] FAIL error_sticky_ack: got %b expected %b", outs, O_ERR);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (outs !== O_ERR) begin
      fails++;
      $display("[TB] FAIL error_sticky_idle: got %b expected %b", outs, O_ERR);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (outs !== O_FRZ) begin
      fails++;
      $display("[TB] FAIL error_reset_outputs: got %b expected %b", outs, O_FRZ);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL error_cleared: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush;
    hif.branch_taken = 1'b1;
    tick();
    hif.branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (outs !== O_FRZ) begin
      fails++;
      $display("[TB] FAIL reset_mid_flush: got %b expected %b", outs, O_FRZ);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL no_residual_flush: got %b expected %b", outs, O_RUN);
    end
`ifdef HAZARD_PERF_EN
    tests++;
    if (flush_cycles !== 32'd0) begin
      fails++;
      $display("[TB] FAIL perf_flush_cleared: got %0d expected 0", flush_cycles);
    end
    tests++;
    if (stall_cycles !== 32'd0) begin
      fails++;
      $display("[TB] FAIL perf_stall_cleared: got %0d expected 0", stall_cycles);
    end
`endif
    tick();
    #1;
    tests++;
    if (outs !== O_RUN) begin
      fails++;
      $display("[TB] FAIL after_reset_run: got %b expected %b", outs, O_RUN);
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_branch_over_hz();
    test_mem_wait();
    test_hz_after_mem();
    test_flush_mem();
    test_timeout();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
